// File: rtl/aposta_entrada_pkg.sv
// Shared definitions for the bet-entry sequencer and its edge detector.
package aposta_entrada_pkg;

  localparam int NUM_W         = 4;
  localparam int N_NUMEROS_DEF = 5;
  localparam int NUM_MAX_DEF   = 15;

  typedef enum logic [1:0] {
    ENTRADA = 2'd0,
    CHEIO   = 2'd1,
    FECHADO = 2'd2
  } estado_t;

endpackage

// File: rtl/aposta_entrada_detector_borda.sv
// Rising-edge detector for a debounced level. The history register presets
// to 1 so a level already high when reset is released never counts as an edge.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_q;

  // Remember last cycle's level; preset high under reset.
  always_ff @(posedge clock) begin
    if (!reset) sinal_q <= 1'b1;
    else        sinal_q <= sinal;
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/aposta_entrada.sv
// Bet-entry sequencer: filters keypad picks (range and repeats), issues one
// numero/insere beat per accepted pick and closes the bet with a single fim.
module aposta_entrada
  import aposta_entrada_pkg::*;
#(
  parameter int N_NUMEROS = N_NUMEROS_DEF,
  parameter int NUM_MAX   = NUM_MAX_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NUM_W-1:0] digito,
  input  logic             tecla,
  input  logic             confirma,
  input  logic             novo_jogo,
  output logic [NUM_W-1:0] numero,
  output logic             insere,
  output logic             fim,
  output logic             erro,
  output logic [2:0]       contagem,
  output logic             cheio
);

  estado_t              estado, estado_next;
  logic [15:0]          mascara, mascara_next;
  logic [2:0]           contagem_next;
  logic [NUM_W-1:0]     numero_next;
  logic                 insere_next, fim_next, erro_next;
  logic                 press;
  logic                 valido;

  detector_borda u_borda (
    .clock (clock),
    .reset (reset),
    .sinal (tecla),
    .borda (press)
  );

  // A pick is usable when it is in range and not already taken in this bet.
  assign valido = (int'(digito) <= NUM_MAX) && !mascara[digito];
  assign cheio  = (int'(contagem) == N_NUMEROS);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) estado <= ENTRADA;
    else        estado <= estado_next;
  end

  // Next state and next output values; novo_jogo beats confirma beats press.
  always_comb begin
    estado_next   = estado;
    mascara_next  = mascara;
    contagem_next = contagem;
    numero_next   = numero;
    insere_next   = 1'b0;
    fim_next      = 1'b0;
    erro_next     = 1'b0;
    if (novo_jogo) begin
      estado_next   = ENTRADA;
      mascara_next  = '0;
      contagem_next = '0;
    end else begin
      case (estado)
        ENTRADA: begin
          if (confirma) begin
            erro_next = 1'b1;
          end else if (press) begin
            if (valido) begin
              numero_next          = digito;
              insere_next          = 1'b1;
              mascara_next[digito] = 1'b1;
              contagem_next        = contagem + 3'd1;
              if (int'(contagem_next) == N_NUMEROS) estado_next = CHEIO;
            end else begin
              erro_next = 1'b1;
            end
          end
        end
        CHEIO: begin
          if (confirma) begin
            fim_next    = 1'b1;
            estado_next = FECHADO;
          end else if (press) begin
            erro_next = 1'b1;
          end
        end
        FECHADO: begin
          // Closed bet: presses and confirms are absorbed silently.
        end
        default: estado_next = ENTRADA;
      endcase
    end
  end

  // Output, mask and counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      numero   <= '0;
      insere   <= 1'b0;
      fim      <= 1'b0;
      erro     <= 1'b0;
      contagem <= '0;
      mascara  <= '0;
    end else begin
      numero   <= numero_next;
      insere   <= insere_next;
      fim      <= fim_next;
      erro     <= erro_next;
      contagem <= contagem_next;
      mascara  <= mascara_next;
    end
  end

endmodule

// File: tb/tb_aposta_entrada.sv
// Directed bench for aposta_entrada plus a short random sequence against a
// small behavioural model; a second instance runs with NUM_MAX=9.
module tb_aposta_entrada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digito = 4'd0;
  logic       tecla = 1'b0;
  logic       confirma = 1'b0;
  logic       novo_jogo = 1'b0;

  logic [3:0] numero, numero9;
  logic       insere, fim, erro, cheio;
  logic       insere9, fim9, erro9, cheio9;
  logic [2:0] contagem, contagem9;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;
  logic [2:0] prev_strb = 3'b000;

  aposta_entrada dut (
    .clock(clock), .reset(reset), .digito(digito), .tecla(tecla),
    .confirma(confirma), .novo_jogo(novo_jogo), .numero(numero),
    .insere(insere), .fim(fim), .erro(erro), .contagem(contagem), .cheio(cheio)
  );

  aposta_entrada #(.N_NUMEROS(5), .NUM_MAX(9)) dut9 (
    .clock(clock), .reset(reset), .digito(digito), .tecla(tecla),
    .confirma(confirma), .novo_jogo(novo_jogo), .numero(numero9),
    .insere(insere9), .fim(fim9), .erro(erro9), .contagem(contagem9), .cheio(cheio9)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    tecla = 1'b0; confirma = 1'b0; novo_jogo = 1'b0;
    tick();
  endtask

  task automatic press(input logic [3:0] d);
    digito = d; tecla = 1'b1;
    tick();
  endtask

  task automatic pick(input string tag, input logic [3:0] d, input logic e_ins,
                      input logic e_err, input logic [3:0] e_num, input logic [2:0] e_cnt);
    press(d);
    check({tag, ".insere"}, insere, e_ins);
    check({tag, ".erro"}, erro, e_err);
    check({tag, ".numero"}, numero, e_num);
    check({tag, ".contagem"}, contagem, e_cnt);
    idle();
  endtask

  // Per-cycle protocol properties on the default instance.
  always @(negedge clock) begin
    if (mon_on) begin
      check("onehot0", $onehot0({insere, erro, fim}), 1);
      check("back_to_back", |({insere, erro, fim} & prev_strb), 0);
      check("saturacao", contagem <= 3'd5, 1);
    end
    prev_strb = {insere, erro, fim};
  end

  int m_est, m_cnt, fcnt, op;
  logic [15:0] m_mask;
  logic [3:0] m_num, d;
  logic e_ins, e_err, e_fim;

  initial begin
    // Reset with the key held down: no press may appear on release.
    tecla = 1'b1;
    tick(); tick();
    check("rst.numero", numero, 0);
    check("rst.insere", insere, 0);
    check("rst.fim", fim, 0);
    check("rst.erro", erro, 0);
    check("rst.contagem", contagem, 0);
    check("rst.cheio", cheio, 0);
    reset = 1'b1;
    tick();
    check("held_key.insere", insere, 0);
    check("held_key.erro", erro, 0);
    idle();
    mon_on = 1'b1;

    // Fill a bet: 5,3,8,2,0.
    pick("t1a", 4'd5, 1, 0, 4'd5, 3'd1);
    pick("t1b", 4'd3, 1, 0, 4'd3, 3'd2);
    pick("t1c", 4'd8, 1, 0, 4'd8, 3'd3);
    pick("t1d", 4'd2, 1, 0, 4'd2, 3'd4);
    check("t1.cheio_early", cheio, 0);
    pick("t1e", 4'd0, 1, 0, 4'd0, 3'd5);
    check("t1.cheio", cheio, 1);
    check("t1.insere_off", insere, 0);

    // Full bet rejects presses, then one fim for a long confirm.
    pick("t4.full", 4'd7, 0, 1, 4'd0, 3'd5);
    fcnt = 0;
    confirma = 1'b1;
    tick();
    check("t4.fim_first", fim, 1);
    fcnt += int'(fim);
    for (int i = 0; i < 3; i++) begin
      tick();
      fcnt += int'(fim);
    end
    idle();
    check("t4.fim_count", fcnt, 1);
    pick("t4.fechado_press", 4'd3, 0, 0, 4'd0, 3'd5);
    confirma = 1'b1;
    tick();
    check("t4.fechado_fim", fim, 0);
    check("t4.fechado_erro", erro, 0);
    idle();

    novo_jogo = 1'b1;
    tick();
    check("novo.contagem", contagem, 0);
    check("novo.cheio", cheio, 0);
    check("novo.numero", numero, 0);
    idle();

    // Repeated pick is rejected.
    pick("t2a", 4'd5, 1, 0, 4'd5, 3'd1);
    pick("t2b", 4'd3, 1, 0, 4'd3, 3'd2);
    pick("t2.repeat", 4'd5, 0, 1, 4'd3, 3'd2);
    check("t2.erro_single", erro, 0);
    confirma = 1'b1;
    tick();
    check("t2.confirm_early.erro", erro, 1);
    check("t2.confirm_early.fim", fim, 0);
    idle();

    // novo_jogo beats a simultaneous press.
    novo_jogo = 1'b1; digito = 4'd6; tecla = 1'b1;
    tick();
    check("prio.np.insere", insere, 0);
    check("prio.np.contagem", contagem, 0);
    idle();
    pick("prio.after", 4'd5, 1, 0, 4'd5, 3'd1);
    novo_jogo = 1'b1;
    tick();
    idle();

    // Range limit: default instance (15) versus NUM_MAX=9 instance.
    press(4'd12);
    check("t3.d12.insere", insere, 1);
    check("t3.d12.numero", numero, 12);
    check("t3.d12.erro9", erro9, 1);
    check("t3.d12.insere9", insere9, 0);
    check("t3.d12.contagem9", contagem9, 0);
    idle();
    press(4'd9);
    check("t3.d9.insere9", insere9, 1);
    check("t3.d9.numero9", numero9, 9);
    check("t3.d9.contagem9", contagem9, 1);
    check("t3.d9.contagem", contagem, 2);
    idle();
    press(4'd15);
    check("t3.d15.insere", insere, 1);
    check("t3.d15.contagem", contagem, 3);
    check("t3.d15.erro9", erro9, 1);
    check("t3.d15.numero9", numero9, 9);
    idle();
    press(4'd12);
    check("t3.rep12.erro", erro, 1);
    check("t3.rep12.erro9", erro9, 1);
    check("t3.rep12.contagem9", contagem9, 1);
    idle();
    pick("t3.d4", 4'd4, 1, 0, 4'd4, 3'd4);
    pick("t3.d1", 4'd1, 1, 0, 4'd1, 3'd5);
    check("t3.contagem9", contagem9, 3);

    // novo_jogo beats confirma on a full bet.
    novo_jogo = 1'b1; confirma = 1'b1;
    tick();
    check("prio.nc.fim", fim, 0);
    check("prio.nc.contagem", contagem, 0);
    check("prio.nc.cheio", cheio, 0);
    idle();

    // Reset mid-bet swallows the pending accept.
    pick("midrst.pre", 4'd2, 1, 0, 4'd2, 3'd1);
    digito = 4'd4; tecla = 1'b1; reset = 1'b0;
    tick();
    check("midrst.insere", insere, 0);
    check("midrst.contagem", contagem, 0);
    check("midrst.numero", numero, 0);
    reset = 1'b1;
    idle();
    pick("midrst.post", 4'd2, 1, 0, 4'd2, 3'd1);
    novo_jogo = 1'b1;
    tick();
    idle();

    // Random event sequence against a behavioural model.
    m_est = 0; m_cnt = 0; m_mask = '0; m_num = 4'd2;
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 11));
      d  = 4'($urandom_range(0, 15));
      e_ins = 1'b0; e_err = 1'b0; e_fim = 1'b0;
      if (op == 11) begin
        novo_jogo = 1'b1;
        m_est = 0; m_cnt = 0; m_mask = '0;
      end else if (op >= 9) begin
        confirma = 1'b1;
        if (m_est == 0) e_err = 1'b1;
        else if (m_est == 1) begin e_fim = 1'b1; m_est = 2; end
      end else begin
        digito = d; tecla = 1'b1;
        if (m_est == 0) begin
          if (m_mask[d]) e_err = 1'b1;
          else begin
            e_ins = 1'b1; m_mask[d] = 1'b1; m_num = d; m_cnt++;
            if (m_cnt == 5) m_est = 1;
          end
        end else if (m_est == 1) e_err = 1'b1;
      end
      tick();
      check("rnd.insere", insere, e_ins);
      check("rnd.erro", erro, e_err);
      check("rnd.fim", fim, e_fim);
      check("rnd.contagem", contagem, m_cnt);
      check("rnd.numero", numero, m_num);
      check("rnd.cheio", cheio, m_cnt == 5);
      idle();
    end

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
